mem_bist_master: RTL and testbench

Built-in self-test initiator for `single_port_memory`: it drives the memory's request side (en / addr / wr_data / rd_wr / err_clr) and consumes its response side (rd_data / error). On a start pulse it runs a two-pass write/read-back march over every address and reports pass/fail, the first failing address and a mismatch count. It sits beside the memory and takes over the port during power-on or on-demand self-test.

---
 rtl/mem_bist_master.sv | 174 +++++++++++++++++
 tb/tb_mem_bist_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_master.sv
// Self-test initiator for single_port_memory: two-pass write/read-back march
// over every address, reporting pass/fail, first failing address and mismatch count.
module mem_bist_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              aborted,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [4:0]        err_count,
    output logic              mem_en,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_err_clr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_error
);

    localparam int REPS   = DATA_W / ADDR_W;
    localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_CMP,
        S_ERR_CLR,
        S_DONE
    } state_t;

    typedef struct packed {
        logic en;
        logic rd_wr;
        logic err_clr;
    } mem_req_t;

    // Pass 0 writes seed ^ replicated address, pass 1 writes its complement.
    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic              p,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] base;
        base = s ^ DATA_W'({REPS{a}});
        return p ? ~base : base;
    endfunction

    state_t              state_q, state_d;
    mem_req_t            req;
    logic [DATA_W-1:0]   seed_q;
    logic                pass_idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [4:0]          err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   fail_addr_q;
    logic                pass_q;
    logic                aborted_q;
    logic [DATA_W-1:0]   exp_data;
    logic                last_addr;
    logic                mismatch;

    assign exp_data  = pattern(seed_q, pass_idx_q, addr_q);
    assign last_addr = (addr_q == {ADDR_W{1'b1}});
    assign mismatch  = (state_q == S_CMP) && (mem_rd_data != exp_data);
    assign err_cnt_d = (mismatch && err_cnt_q != 5'd31) ? err_cnt_q + 5'd1 : err_cnt_q;

    always_comb begin
        state_d = state_q;
        req     = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WR;
            end
            S_WR: begin
                busy      = 1'b1;
                req.en    = 1'b1;
                req.rd_wr = 1'b1;
                if (last_addr) state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                busy    = 1'b1;
                req.en  = 1'b1;
                state_d = (RD_LAT == 1) ? S_CMP : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                busy = 1'b1;
                if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = S_CMP;
            end
            S_CMP: begin
                busy = 1'b1;
                if (!last_addr)      state_d = S_RD_REQ;
                else if (pass_idx_q) state_d = S_DONE;
                else                 state_d = S_WR;
            end
            S_ERR_CLR: begin
                busy        = 1'b1;
                req.err_clr = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A memory error aborts the march; a same-edge mismatch is still counted below.
        if (busy && state_q != S_ERR_CLR && mem_error) state_d = S_ERR_CLR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            pass_idx_q  <= 1'b0;
            addr_q      <= '0;
            wait_q      <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seed_q      <= seed;
                        pass_idx_q  <= 1'b0;
                        addr_q      <= '0;
                        err_cnt_q   <= '0;
                        fail_addr_q <= '0;
                        pass_q      <= 1'b0;
                        aborted_q   <= 1'b0;
                    end
                end
                S_WR:      addr_q <= addr_q + 1'b1;
                S_RD_REQ:  wait_q <= '0;
                S_RD_WAIT: wait_q <= wait_q + 1'b1;
                S_CMP: begin
                    err_cnt_q <= err_cnt_d;
                    if (mismatch && err_cnt_q == 5'd0) fail_addr_q <= addr_q;
                    // Address wraps to 0 between passes and parks on the top address at the end.
                    if (!(last_addr && pass_idx_q)) addr_q <= addr_q + 1'b1;
                    if (last_addr) pass_idx_q <= 1'b1;
                    if (state_d == S_DONE) pass_q <= (err_cnt_d == 5'd0);
                end
                S_ERR_CLR: begin
                    aborted_q <= 1'b1;
                    pass_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_en      = req.en;
    assign mem_rd_wr   = req.rd_wr;
    assign mem_err_clr = req.err_clr;
    assign mem_addr    = addr_q;
    assign mem_wr_data = exp_data;
    assign pass        = pass_q;
    assign aborted     = aborted_q;
    assign fail_addr   = fail_addr_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Randomised bench for mem_bist_master: memory model with stuck-bit faults and
// error injection, cycle-indexed behavioural reference, plus literal pins.
module tb_mem_bist_master;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic lat_sel = 1'b0;
    always #5 clk = ~clk;

    logic busy1, done1, pass1, ab1, en1, rw1, clr1;
    logic busy2, done2, pass2, ab2, en2, rw2, clr2;
    logic [AW-1:0] fa1, addr1, fa2, addr2;
    logic [4:0] ec1, ec2;
    logic [DW-1:0] wd1, wd2;
    logic [DW-1:0] mem_rd_data;
    logic mem_error;
    logic start1, start2;
    assign start1 = start & ~lat_sel;
    assign start2 = start & lat_sel;

    mem_bist_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .seed(seed),
        .busy(busy1), .done(done1), .pass(pass1), .aborted(ab1),
        .fail_addr(fa1), .err_count(ec1), .mem_en(en1), .mem_rd_wr(rw1),
        .mem_addr(addr1), .mem_wr_data(wd1), .mem_err_clr(clr1),
        .mem_rd_data(mem_rd_data), .mem_error(mem_error));

    mem_bist_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .seed(seed),
        .busy(busy2), .done(done2), .pass(pass2), .aborted(ab2),
        .fail_addr(fa2), .err_count(ec2), .mem_en(en2), .mem_rd_wr(rw2),
        .mem_addr(addr2), .mem_wr_data(wd2), .mem_err_clr(clr2),
        .mem_rd_data(mem_rd_data), .mem_error(mem_error));

    logic o_busy, o_done, o_pass, o_ab, o_en, o_rw, o_clr;
    logic [AW-1:0] o_fa, o_addr;
    logic [4:0] o_ec;
    logic [DW-1:0] o_wd;
    assign o_busy = lat_sel ? busy2 : busy1;
    assign o_done = lat_sel ? done2 : done1;
    assign o_pass = lat_sel ? pass2 : pass1;
    assign o_ab   = lat_sel ? ab2   : ab1;
    assign o_en   = lat_sel ? en2   : en1;
    assign o_rw   = lat_sel ? rw2   : rw1;
    assign o_clr  = lat_sel ? clr2  : clr1;
    assign o_fa   = lat_sel ? fa2   : fa1;
    assign o_addr = lat_sel ? addr2 : addr1;
    assign o_ec   = lat_sel ? ec2   : ec1;
    assign o_wd   = lat_sel ? wd2   : wd1;

    // Memory model: stuck bits applied on read, 1- or 2-stage read pipe, sticky error.
    logic [DW-1:0] mem [D];
    logic [DW-1:0] stk_mask [D];
    logic [DW-1:0] stk_val [D];
    logic [DW-1:0] pipe0 = '0;
    logic [DW-1:0] pipe1 = '0;
    logic err_q = 1'b0;
    int cyc = 0;
    int err_abs = -100;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (o_en && o_rw) mem[o_addr] <= o_wd;
        if (o_en && !o_rw)
            pipe0 <= (mem[o_addr] & ~stk_mask[o_addr]) | (stk_val[o_addr] & stk_mask[o_addr]);
        pipe1 <= pipe0;
        if (cyc + 1 == err_abs) err_q <= 1'b1;
        else if (o_clr)         err_q <= 1'b0;
    end
    assign mem_rd_data = lat_sel ? pipe1 : pipe0;
    assign mem_error   = err_q;

    int lat = 1;
    int t0 = 0;
    int err_k = 0;
    logic [DW-1:0] m_seed = '0;
    int checks = 0;
    int fails = 0;
    int done_at = -1;
    int clr_at = -1;

    function automatic logic [DW-1:0] e_of(input int p, input int a);
        logic [3:0] a4;
        logic [DW-1:0] v;
        a4 = a[3:0];
        v = m_seed ^ {4{a4}};
        return (p != 0) ? ~v : v;
    endfunction

    function automatic bit mism(input int p, input int a);
        logic [DW-1:0] e;
        e = e_of(p, a);
        return ((e & ~stk_mask[a]) | (stk_val[a] & stk_mask[a])) != e;
    endfunction

    function automatic int done_k();
        int P;
        P = D * (2 + lat);
        return (err_k > 0) ? err_k + 2 : 2 * P + 1;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, k, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < D; i++) begin
            stk_mask[i] = '0;
            stk_val[i]  = '0;
        end
    endtask

    // Expected outputs for cycle k after the start cycle, from the march schedule.
    task automatic check_cycle(input int k);
        int P, dk, j, p, r, q, cnt, fa, a2;
        bit act;
        logic eb, ed, een, erw, eclr, epass, eab;
        logic [31:0] eaddr, ewd;
        P = D * (2 + lat);
        dk = done_k();
        eb = (k < dk);
        ed = (k == dk);
        een = 1'b0; erw = 1'b0; eaddr = 0; ewd = 0;
        eclr = (err_k > 0) && (k == err_k + 1);
        act = (k < dk) && (err_k == 0 || k <= err_k);
        if (act) begin
            j = k - 1; p = j / P; r = j % P;
            if (r < D) begin
                een = 1'b1; erw = 1'b1; eaddr = r; ewd = 32'(e_of(p, r));
            end else begin
                q = r - D;
                if (q % (1 + lat) == 0) begin
                    een = 1'b1; eaddr = q / (1 + lat);
                end
            end
        end
        cnt = 0; fa = 0;
        for (int c = 1; c < k; c++) begin
            if (c <= 2 * P && (err_k == 0 || c <= err_k)) begin
                j = c - 1; r = j % P;
                if (r >= D && (r - D) % (1 + lat) == lat) begin
                    a2 = (r - D) / (1 + lat);
                    if (mism(j / P, a2)) begin
                        if (cnt == 0) fa = a2;
                        cnt++;
                    end
                end
            end
        end
        if (cnt > 31) cnt = 31;
        epass = (k >= dk) && (cnt == 0) && (err_k == 0);
        eab   = (k >= dk) && (err_k > 0);
        chk("busy", k, 32'(o_busy), 32'(eb));
        chk("done", k, 32'(o_done), 32'(ed));
        chk("mem_en", k, 32'(o_en), 32'(een));
        chk("mem_err_clr", k, 32'(o_clr), 32'(eclr));
        chk("err_count", k, 32'(o_ec), cnt);
        chk("fail_addr", k, 32'(o_fa), fa);
        chk("pass", k, 32'(o_pass), 32'(epass));
        chk("aborted", k, 32'(o_ab), 32'(eab));
        if (een) begin
            chk("mem_rd_wr", k, 32'(o_rw), 32'(erw));
            chk("mem_addr", k, 32'(o_addr), eaddr);
            if (erw) chk("mem_wr_data", k, 32'(o_wd), ewd);
        end
    endtask

    task automatic run(input bit ls, input logic [DW-1:0] sd, input int ek, input int rk,
                       input bit fixed_starts, input bit rnd_starts);
        int dk;
        lat_sel = ls;
        lat = ls ? 2 : 1;
        err_k = ek;
        done_at = -1;
        clr_at = -1;
        @(negedge clk);
        t0 = cyc;
        m_seed = sd;
        seed = sd;
        start = 1'b1;
        err_abs = (ek > 0) ? t0 + ek : -100;
        dk = done_k();
        for (int k = 1; k <= dk + 3; k++) begin
            @(negedge clk);
            check_cycle(k);
            if (o_done) done_at = k;
            if (o_clr) clr_at = k;
            if (rk > 0 && k == rk) begin
                #1 reset = 1'b0;
                #1;
                chk("rst_busy", k, 32'(o_busy), 0);
                chk("rst_done", k, 32'(o_done), 0);
                chk("rst_pass", k, 32'(o_pass), 0);
                chk("rst_aborted", k, 32'(o_ab), 0);
                chk("rst_fail_addr", k, 32'(o_fa), 0);
                chk("rst_err_count", k, 32'(o_ec), 0);
                chk("rst_mem_en", k, 32'(o_en), 0);
                chk("rst_mem_rd_wr", k, 32'(o_rw), 0);
                chk("rst_mem_addr", k, 32'(o_addr), 0);
                chk("rst_mem_wr_data", k, 32'(o_wd), 0);
                chk("rst_mem_err_clr", k, 32'(o_clr), 0);
                start = 1'b0;
                @(negedge clk);
                chk("rst_hold_done", k + 1, 32'(o_done), 0);
                chk("rst_hold_en", k + 1, 32'(o_en), 0);
                reset = 1'b1;
                @(negedge clk);
                chk("post_rst_busy", k + 2, 32'(o_busy), 0);
                chk("post_rst_done", k + 2, 32'(o_done), 0);
                err_abs = -100;
                return;
            end
            start = ((fixed_starts && (k == 10 || k == 50)) ||
                     (rnd_starts && k < dk && $urandom_range(0, 15) == 0)) ? 1'b1 : 1'b0;
            seed = DW'($urandom);
        end
        start = 1'b0;
        err_abs = -100;
    endtask

    initial begin
        int nf, a, ek, l, P;
        clear_faults();
        #1 reset = 1'b0;
        #1;
        chk("reset_busy", 0, 32'(o_busy), 0);
        chk("reset_done", 0, 32'(o_done), 0);
        chk("reset_pass", 0, 32'(o_pass), 0);
        chk("reset_mem_en", 0, 32'(o_en), 0);
        chk("reset_err_count", 0, 32'(o_ec), 0);
        chk("reset_mem_wr_data", 0, 32'(o_wd), 0);
        @(negedge clk);
        reset = 1'b1;

        // Ideal memory, seed 0.
        run(1'b0, 16'h0000, 0, 0, 1'b0, 1'b0);
        chk("t1_done_cycle", 0, done_at, 97);
        chk("t1_pass", 0, 32'(o_pass), 1);
        chk("t1_err_count", 0, 32'(o_ec), 0);
        chk("t1_fail_addr", 0, 32'(o_fa), 0);
        chk("t1_aborted", 0, 32'(o_ab), 0);

        // Address 5 bit 0 stuck at 0: only the pass-0 read (16'h5555) fails.
        stk_mask[5] = 16'h0001;
        stk_val[5] = 16'h0000;
        run(1'b0, 16'h0000, 0, 0, 1'b0, 1'b0);
        chk("t2_done_cycle", 0, done_at, 97);
        chk("t2_err_count", 0, 32'(o_ec), 1);
        chk("t2_fail_addr", 0, 32'(o_fa), 5);
        chk("t2_pass", 0, 32'(o_pass), 0);
        clear_faults();

        // Memory error in cycle 20.
        run(1'b0, 16'h1234, 20, 0, 1'b0, 1'b0);
        chk("t3_clr_cycle", 0, clr_at, 21);
        chk("t3_done_cycle", 0, done_at, 22);
        chk("t3_aborted", 0, 32'(o_ab), 1);
        chk("t3_pass", 0, 32'(o_pass), 0);

        // Extra starts in cycles 10 and 50 are ignored.
        run(1'b0, 16'h0000, 0, 0, 1'b1, 1'b0);
        chk("t4_done_cycle", 0, done_at, 97);
        chk("t4_pass", 0, 32'(o_pass), 1);

        // Reset in cycle 30, then a fresh run.
        run(1'b0, 16'hBEEF, 0, 30, 1'b0, 1'b0);
        run(1'b0, DW'($urandom), 0, 0, 1'b0, 1'b0);
        chk("t5_done_cycle", 0, done_at, 97);
        chk("t5_pass", 0, 32'(o_pass), 1);

        // Two-cycle read latency.
        run(1'b1, 16'hFFFF, 0, 0, 1'b0, 1'b0);
        chk("t6_done_cycle", 0, done_at, 129);
        chk("t6_pass", 0, 32'(o_pass), 1);

        // Every read mismatches in both passes: count saturates.
        for (int i = 0; i < D; i++) begin
            stk_mask[i] = 16'hFFFF;
            stk_val[i] = 16'h000F;
        end
        run(1'b0, 16'h0000, 0, 0, 1'b0, 1'b0);
        chk("t7_err_count", 0, 32'(o_ec), 31);
        chk("t7_fail_addr", 0, 32'(o_fa), 0);
        chk("t7_pass", 0, 32'(o_pass), 0);
        clear_faults();

        // Randomised runs: faults, seeds, latency, aborts and ignored starts.
        for (int t = 0; t < 12; t++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, D - 1);
                stk_mask[a] = (DW'(1) << $urandom_range(0, DW - 1)) |
                              (($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'(0));
                stk_val[a] = DW'($urandom);
            end
            l = $urandom_range(1, 2);
            P = D * (2 + l);
            ek = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * P) : 0;
            run(l == 2, DW'($urandom), ek, 0, 1'b0, 1'b1);
        end
        clear_faults();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
